line_state_mem: RTL and testbench
=================================

// Module: line_state_mem
// PURPOSE
//  Per-line state store for the cache: NUM_WAYS valid bits and NUM_WAYS dirty bits per index.
//  Registered read port, single op-coded write port, and a flush walker FSM that:
//   - invalidates every line;
//   - hands dirty lines to the writeback path through a req/ack handshake.
//  Sits beside the tag/data memories; the cache controller drives reads, writes and flush.
// PARAMETERS
//  NUM_LINES  default NUM_CACHE_LINES  lines per way (power of 2)
//  NUM_WAYS   default 1                ways per index (1 = direct-mapped)
//  IDX_W      default $clog2(NUM_LINES) index width (derived, not overridden)
//  WAY_W      default (NUM_WAYS>1)?$clog2(NUM_WAYS):1  way-select width
// PORTS
//  clk          in   1         clock, rising edge
//  resetn       in   1         asynchronous active-low reset
//  rd_en        in   1         read request
//  rd_index     in   IDX_W     read index
//  rd_valid     out  NUM_WAYS  valid bits of rd_index, registered
//  rd_dirty     out  NUM_WAYS  dirty bits of rd_index, registered
//  wr_en        in   1         write request
//  wr_index     in   IDX_W     write index
//  wr_way       in   WAY_W     write way
//  wr_op        in   2         line_op_t: OP_FILL, OP_MARK_DIRTY, OP_INVALIDATE
//  flush_req    in   1         start flush walk (pulse)
//  flush_busy   out  1         walker active
//  flush_done   out  1         one-cycle pulse when walk completes
//  wb_req       out  1         dirty line needs writeback
//  wb_index     out  IDX_W     index of that line
//  wb_way       out  WAY_W     way of that line
//  wb_ack       in   1         writeback accepted
// BEHAVIOUR
//  Reset (async, resetn=0): all valid/dirty bits, rd_valid, rd_dirty, flush_busy, flush_done,
//   wb_req, wb_index and wb_way go to 0; FSM enters IDLE. Reset mid-flush aborts the walk
//   with no flush_done pulse.
//  Read: rd_en at edge N -> rd_valid/rd_dirty valid after edge N, held until next rd_en.
//   A same-cycle write to the same index is bypassed, so the read returns the post-write value.
//  Write ops (applied at the edge, wr_en=1):
//   OP_FILL        valid=1, dirty=0.
//   OP_MARK_DIRTY  dirty=1 only when valid=1; on an invalid line it has no effect.
//   OP_INVALIDATE  valid=0, dirty=0.
//   Encoding 2'b11 is reserved and treated as a no-op.
//  Flush FSM states IDLE -> SCAN -> (WB_WAIT) -> DONE -> IDLE:
//   IDLE: flush_req=1 -> SCAN, walk pointer {idx,way}=0, flush_busy=1.
//   SCAN: visits one {idx,way} per cycle, way innermost.
//    - valid & dirty: latch wb_index/wb_way, raise wb_req, go to WB_WAIT.
//    - otherwise: clear the entry and advance.
//    - last entry done -> DONE.
//   WB_WAIT: wb_req stays high with stable index/way until wb_ack=1 is sampled. On that edge:
//    clear the entry, drop wb_req, advance or go to DONE. wb_ack while wb_req=0 is ignored.
//   DONE: flush_done=1 for one cycle, flush_busy=0 from the next edge, -> IDLE.
//   Clean flush latency: NUM_LINES*NUM_WAYS SCAN cycles plus 1 DONE cycle.
//  While flush_busy=1: wr_en and flush_req are ignored; reads are still serviced.
//  The walk pointer does not wrap; SCAN exits on the last entry.
// CONFIGURATION
//  LINE_STATE_DIRTY_EN defined:
//   dirty array, OP_MARK_DIRTY, and the writeback handshake as described above.
//  LINE_STATE_DIRTY_EN undefined:
//   - no dirty storage; rd_dirty ties to 0 and OP_MARK_DIRTY is a no-op;
//   - WB_WAIT is removed and wb_req ties to 0;
//   - flush is a pure invalidate walk with the same latency as a clean flush.
// STRUCTURE
//  Package memory_sub_system_param holds:
//   - NUM_CACHE_LINES and INDEX_LENGTH;
//   - line_op_t enum {OP_FILL=0, OP_MARK_DIRTY=1, OP_INVALIDATE=2};
//   - flush_state_t enum {IDLE, SCAN, WB_WAIT, DONE}.
//  One sub-module, flush_walker: FSM, walk pointer and wb handshake. It issues clear strobes
//   into the state arrays owned by line_state_mem.
// TESTING
//  1. Reset: resetn=0 mid-traffic -> every rd_valid/rd_dirty=0; flush_busy=0; wb_req=0.
//  2. Fill/read: OP_FILL idx 5 way 0, then rd_en idx 5 -> rd_valid=1, rd_dirty=0 one cycle
//     later; an idx 6 read returns 0.
//  3. Bypass: OP_MARK_DIRTY idx 5 in the same cycle as rd_en idx 5 -> rd_dirty=1.
//     OP_MARK_DIRTY on invalid idx 7 -> idx 7 reads 0/0.
//  4. Clean flush, NUM_LINES=8, NUM_WAYS=2, no dirty lines -> flush_done exactly 17 cycles
//     after flush_req; all valid bits 0.
//  5. Dirty flush: lines idx 3 way 1 dirty; hold wb_ack low 4 cycles -> wb_req stays high
//     with wb_index=3 and wb_way=1; ack clears it; walk continues; flush_done arrives.
//     wr_en during the flush has no effect.
//  6. resetn=0 during WB_WAIT -> wb_req=0 and flush_busy=0 immediately; no flush_done pulse.

Source files
------------

// File: rtl/line_state_mem_pkg.sv
// Shared types for the line-state store: cache geometry, write op codes, flush walker states.
package memory_sub_system_param;

  localparam int NUM_CACHE_LINES = 64;
  localparam int INDEX_LENGTH    = $clog2(NUM_CACHE_LINES);

  typedef enum logic [1:0] {
    OP_FILL       = 2'd0,
    OP_MARK_DIRTY = 2'd1,
    OP_INVALIDATE = 2'd2
  } line_op_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    WB_WAIT = 2'd2,
    DONE    = 2'd3
  } flush_state_t;

endpackage

// File: rtl/line_state_mem_flush_walker.sv
// Flush walker: visits every {index,way} once, clearing entries and handing dirty ones to writeback.
// LINE_STATE_DIRTY_EN enables the WB_WAIT writeback handshake; otherwise it is a pure invalidate walk.
module flush_walker
  import memory_sub_system_param::*;
#(
  parameter int NUM_LINES = 8,
  parameter int NUM_WAYS  = 1,
  parameter int IDX_W     = 3,
  parameter int WAY_W     = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush_req,
  input  logic             cur_needs_wb,
  input  logic             wb_ack,
  output logic [IDX_W-1:0] walk_index,
  output logic [WAY_W-1:0] walk_way,
  output logic             clr_en,
  output logic             flush_busy,
  output logic             flush_done,
  output logic             wb_req,
  output logic [IDX_W-1:0] wb_index,
  output logic [WAY_W-1:0] wb_way,
  output flush_state_t     state
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LINES - 1);
  localparam logic [WAY_W-1:0] LAST_WAY = WAY_W'(NUM_WAYS - 1);

  flush_state_t     state_d;
  logic [IDX_W-1:0] idx_d;
  logic [WAY_W-1:0] way_d;
  logic             advance;
  logic             last_entry;
  logic             take_wb;

  assign last_entry = (walk_index == LAST_IDX) && (walk_way == LAST_WAY);

`ifdef LINE_STATE_DIRTY_EN
  assign take_wb = cur_needs_wb;
`else
  logic unused_wb;
  assign take_wb   = 1'b0;
  assign unused_wb = cur_needs_wb ^ wb_ack;
`endif

  always_comb begin
    state_d = state;
    idx_d   = walk_index;
    way_d   = walk_way;
    clr_en  = 1'b0;
    advance = 1'b0;
    case (state)
      IDLE: begin
        if (flush_req) begin
          state_d = SCAN;
          idx_d   = '0;
          way_d   = '0;
        end
      end
      SCAN: begin
        if (take_wb) begin
          state_d = WB_WAIT;
        end else begin
          clr_en  = 1'b1;
          advance = 1'b1;
        end
      end
`ifdef LINE_STATE_DIRTY_EN
      WB_WAIT: begin
        if (wb_ack) begin
          clr_en  = 1'b1;
          advance = 1'b1;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Way is the inner loop; the pointer never wraps, the last entry exits to DONE.
    if (advance) begin
      if (last_entry) begin
        state_d = DONE;
      end else if (walk_way == LAST_WAY) begin
        way_d = '0;
        idx_d = walk_index + IDX_W'(1);
      end else begin
        way_d = walk_way + WAY_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      walk_index <= '0;
      walk_way   <= '0;
      flush_busy <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      state      <= state_d;
      walk_index <= idx_d;
      walk_way   <= way_d;
      flush_busy <= (state_d != IDLE);
      flush_done <= (state_d == DONE);
    end
  end

`ifdef LINE_STATE_DIRTY_EN
  // Request: wb_req rises when a dirty entry is found and holds index/way stable until wb_ack is sampled.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wb_req   <= 1'b0;
      wb_index <= '0;
      wb_way   <= '0;
    end else if (state == SCAN && take_wb) begin
      wb_req   <= 1'b1;
      wb_index <= walk_index;
      wb_way   <= walk_way;
    end else if (state == WB_WAIT && wb_ack) begin
      wb_req   <= 1'b0;
    end
  end
`else
  assign wb_req   = 1'b0;
  assign wb_index = '0;
  assign wb_way   = '0;
`endif

endmodule

// File: rtl/line_state_mem.sv
// Per-line valid/dirty store with registered bypassed read, op-coded write and a flush walker.
// LINE_STATE_DIRTY_EN adds dirty storage, OP_MARK_DIRTY and the writeback handshake.
module line_state_mem
  import memory_sub_system_param::*;
#(
  parameter int  NUM_LINES = NUM_CACHE_LINES,
  parameter int  NUM_WAYS  = 1,
  parameter int  WAY_W     = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
  localparam int IDX_W     = $clog2(NUM_LINES)
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                rd_en,
  input  logic [IDX_W-1:0]    rd_index,
  output logic [NUM_WAYS-1:0] rd_valid,
  output logic [NUM_WAYS-1:0] rd_dirty,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_index,
  input  logic [WAY_W-1:0]    wr_way,
  input  logic [1:0]          wr_op,
  input  logic                flush_req,
  output logic                flush_busy,
  output logic                flush_done,
  output logic                wb_req,
  output logic [IDX_W-1:0]    wb_index,
  output logic [WAY_W-1:0]    wb_way,
  input  logic                wb_ack,
  output logic [1:0]          flush_state
);

  logic [NUM_WAYS-1:0] valid_q [NUM_LINES];
  logic [NUM_WAYS-1:0] valid_d [NUM_LINES];
  logic [IDX_W-1:0]    walk_index;
  logic [WAY_W-1:0]    walk_way;
  logic                clr_en;
  logic                cur_needs_wb;
  logic                wr_ok;

  // Host writes are locked out for the whole walk, so they never race the clear strobe.
  assign wr_ok = wr_en && !flush_busy;

  flush_walker #(
    .NUM_LINES (NUM_LINES),
    .NUM_WAYS  (NUM_WAYS),
    .IDX_W     (IDX_W),
    .WAY_W     (WAY_W)
  ) u_walker (
    .clk          (clk),
    .resetn       (resetn),
    .flush_req    (flush_req),
    .cur_needs_wb (cur_needs_wb),
    .wb_ack       (wb_ack),
    .walk_index   (walk_index),
    .walk_way     (walk_way),
    .clr_en       (clr_en),
    .flush_busy   (flush_busy),
    .flush_done   (flush_done),
    .wb_req       (wb_req),
    .wb_index     (wb_index),
    .wb_way       (wb_way),
    .state        (flush_state)
  );

  always_comb begin
    valid_d = valid_q;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (wr_ok && wr_way == WAY_W'(w)) begin
        if (wr_op == OP_FILL)            valid_d[wr_index][w] = 1'b1;
        else if (wr_op == OP_INVALIDATE) valid_d[wr_index][w] = 1'b0;
      end
      if (clr_en && walk_way == WAY_W'(w)) valid_d[walk_index][w] = 1'b0;
    end
  end

  // Reads sample the next-state array, which gives the same-cycle write bypass.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_LINES; i++) valid_q[i] <= '0;
      rd_valid <= '0;
    end else begin
      valid_q <= valid_d;
      if (rd_en) rd_valid <= valid_d[rd_index];
    end
  end

`ifdef LINE_STATE_DIRTY_EN
  logic [NUM_WAYS-1:0] dirty_q [NUM_LINES];
  logic [NUM_WAYS-1:0] dirty_d [NUM_LINES];

  always_comb begin
    dirty_d = dirty_q;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (wr_ok && wr_way == WAY_W'(w)) begin
        if (wr_op == OP_FILL || wr_op == OP_INVALIDATE)
          dirty_d[wr_index][w] = 1'b0;
        else if (wr_op == OP_MARK_DIRTY && valid_q[wr_index][w])
          dirty_d[wr_index][w] = 1'b1;
      end
      if (clr_en && walk_way == WAY_W'(w)) dirty_d[walk_index][w] = 1'b0;
    end
  end

  always_comb begin
    cur_needs_wb = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (walk_way == WAY_W'(w))
        cur_needs_wb = valid_q[walk_index][w] & dirty_q[walk_index][w];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_LINES; i++) dirty_q[i] <= '0;
      rd_dirty <= '0;
    end else begin
      dirty_q <= dirty_d;
      if (rd_en) rd_dirty <= dirty_d[rd_index];
    end
  end
`else
  assign cur_needs_wb = 1'b0;
  assign rd_dirty     = '0;
`endif

endmodule

// File: tb/tb_line_state_mem.sv
// Bench for line_state_mem (8 lines x 2 ways): directed steps plus random traffic against a line-level model.
module tb_line_state_mem;
  import memory_sub_system_param::*;

  localparam int NL = 8;
  localparam int NW = 2;
  localparam int IW = 3;
  localparam int WW = 1;
  localparam int NE = NL * NW;
`ifdef LINE_STATE_DIRTY_EN
  localparam bit DIRTY_EN = 1'b1;
`else
  localparam bit DIRTY_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          rd_en = 1'b0;
  logic [IW-1:0] rd_index = '0;
  logic [NW-1:0] rd_valid, rd_dirty;
  logic          wr_en = 1'b0;
  logic [IW-1:0] wr_index = '0;
  logic [WW-1:0] wr_way = '0;
  logic [1:0]    wr_op = '0;
  logic          flush_req = 1'b0;
  logic          flush_busy, flush_done, wb_req;
  logic [IW-1:0] wb_index;
  logic [WW-1:0] wb_way;
  logic          wb_ack = 1'b0;
  logic [1:0]    flush_state;

  int checks = 0;
  int errors = 0;

  // Line-level model: one bit per {index,way}; reads return the state after that edge's write.
  bit         m_valid [NL][NW];
  bit         m_dirty [NL][NW];
  bit         m_busy = 1'b0;
  logic [3:0] exp_q[$];
  logic [1:0] exp_rv = '0;
  logic [1:0] exp_rd = '0;

  line_state_mem #(.NUM_LINES(NL), .NUM_WAYS(NW)) dut (
    .clk(clk), .resetn(resetn),
    .rd_en(rd_en), .rd_index(rd_index), .rd_valid(rd_valid), .rd_dirty(rd_dirty),
    .wr_en(wr_en), .wr_index(wr_index), .wr_way(wr_way), .wr_op(wr_op),
    .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done),
    .wb_req(wb_req), .wb_index(wb_index), .wb_way(wb_way), .wb_ack(wb_ack),
    .flush_state(flush_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_write(input int idx, input int way, input logic [1:0] op);
    case (op)
      2'd0: begin m_valid[idx][way] = 1'b1; m_dirty[idx][way] = 1'b0; end
      2'd1: if (m_valid[idx][way] && DIRTY_EN) m_dirty[idx][way] = 1'b1;
      2'd2: begin m_valid[idx][way] = 1'b0; m_dirty[idx][way] = 1'b0; end
      default: ;
    endcase
  endtask

  task automatic model_clear();
    for (int i = 0; i < NL; i++)
      for (int w = 0; w < NW; w++) begin
        m_valid[i][w] = 1'b0;
        m_dirty[i][w] = 1'b0;
      end
    exp_q.delete();
    exp_rv = '0;
    exp_rd = '0;
    m_busy = 1'b0;
  endtask

  // One clock: sample #1 after the edge, update the model with the inputs seen at that edge, check the read port.
  task automatic cycle();
    logic [3:0] row;
    @(posedge clk);
    #1;
    if (wr_en && !m_busy) model_write(int'(wr_index), int'(wr_way), wr_op);
    if (rd_en) begin
      row = '0;
      for (int w = 0; w < NW; w++) begin
        row[w]      = m_valid[rd_index][w];
        row[NW + w] = m_dirty[rd_index][w];
      end
      exp_q.push_back(row);
    end
    if (exp_q.size() > 0) begin
      row    = exp_q.pop_front();
      exp_rv = row[1:0];
      exp_rd = row[3:2];
    end
    chk("rd_valid", 32'(rd_valid), 32'(exp_rv));
    chk("rd_dirty", 32'(rd_dirty), 32'(exp_rd));
  endtask

  task automatic do_write(input int idx, input int way, input logic [1:0] op);
    wr_en = 1'b1; wr_index = IW'(idx); wr_way = WW'(way); wr_op = op;
    cycle();
    wr_en = 1'b0;
  endtask

  task automatic read_all();
    for (int i = 0; i < NL; i++) begin
      rd_en = 1'b1; rd_index = IW'(i);
      cycle();
    end
    rd_en = 1'b0;
  endtask

  task automatic async_reset(input string tag);
    #2 resetn = 1'b0;
    #1;
    chk({tag, "_rd_valid"}, 32'(rd_valid), 0);
    chk({tag, "_rd_dirty"}, 32'(rd_dirty), 0);
    chk({tag, "_busy"}, 32'(flush_busy), 0);
    chk({tag, "_done"}, 32'(flush_done), 0);
    chk({tag, "_wb_req"}, 32'(wb_req), 0);
    chk({tag, "_wb_index"}, 32'(wb_index), 0);
    chk({tag, "_wb_way"}, 32'(wb_way), 0);
    chk({tag, "_state"}, 32'(flush_state), 32'(IDLE));
    wr_en = 1'b0; rd_en = 1'b0; flush_req = 1'b0; wb_ack = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  // Expected walk order is entry e -> index e/NW, way e%NW; dirty entries wait ack_delay cycles for wb_ack.
  task automatic run_flush(input int ack_delay, output int edges);
    int idx, way;
    bit wb_exp;
    flush_req = 1'b1;
    cycle();
    flush_req = 1'b0;
    m_busy = 1'b1;
    edges = 1;
    chk("flush_busy_start", 32'(flush_busy), 1);
    for (int e = 0; e < NE; e++) begin
      idx = e / NW;
      way = e % NW;
      wb_exp = m_valid[idx][way] && m_dirty[idx][way];
      if (e == 0) wb_ack = 1'b1;
      if (e == 1) begin wr_en = 1'b1; wr_index = '0; wr_way = '0; wr_op = OP_FILL; end
      cycle();
      edges++;
      wb_ack = 1'b0;
      wr_en = 1'b0;
      if (wb_exp) begin
        chk("wb_req_rise", 32'(wb_req), 1);
        chk("wb_index", 32'(wb_index), 32'(idx));
        chk("wb_way", 32'(wb_way), 32'(way));
        for (int d = 0; d < ack_delay; d++) begin
          wr_en = 1'b1; wr_index = 3'd1; wr_way = '0; wr_op = OP_FILL;
          cycle();
          edges++;
          wr_en = 1'b0;
          chk("wb_req_hold", 32'(wb_req), 1);
          chk("wb_index_hold", 32'(wb_index), 32'(idx));
          chk("wb_way_hold", 32'(wb_way), 32'(way));
          chk("busy_in_wait", 32'(flush_busy), 1);
        end
        wb_ack = 1'b1;
        cycle();
        edges++;
        wb_ack = 1'b0;
      end
      chk("wb_req_low", 32'(wb_req), 0);
      chk("flush_done_at_entry", 32'(flush_done), 32'(e == NE - 1));
      chk("flush_busy_walk", 32'(flush_busy), 1);
      m_valid[idx][way] = 1'b0;
      m_dirty[idx][way] = 1'b0;
    end
    cycle();
    chk("flush_busy_end", 32'(flush_busy), 0);
    chk("flush_done_end", 32'(flush_done), 0);
    m_busy = 1'b0;
  endtask

  initial begin
    int n;
    int exp_n;
    bit exp_wb;
    model_clear();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rd_valid", 32'(rd_valid), 0);
    chk("reset_rd_dirty", 32'(rd_dirty), 0);
    chk("reset_busy", 32'(flush_busy), 0);
    chk("reset_done", 32'(flush_done), 0);
    chk("reset_wb_req", 32'(wb_req), 0);
    chk("reset_state", 32'(flush_state), 32'(IDLE));
    resetn = 1'b1;
    cycle();

    // Fill and read back; neighbouring index stays empty
    do_write(5, 0, OP_FILL);
    rd_en = 1'b1; rd_index = 3'd5; cycle();
    chk("fill_idx5_valid", 32'(rd_valid), 32'(2'b01));
    rd_index = 3'd6; cycle();
    chk("idx6_empty", 32'(rd_valid), 0);
    rd_en = 1'b0;

    // Same-cycle mark-dirty bypass, and mark-dirty on an invalid line
    wr_en = 1'b1; wr_index = 3'd5; wr_way = 1'b0; wr_op = OP_MARK_DIRTY;
    rd_en = 1'b1; rd_index = 3'd5;
    cycle();
    chk("bypass_dirty", 32'(rd_dirty), 32'({1'b0, DIRTY_EN}));
    wr_index = 3'd7; rd_en = 1'b0;
    cycle();
    wr_en = 1'b0; rd_en = 1'b1; rd_index = 3'd7;
    cycle();
    rd_en = 1'b0;
    chk("idx7_valid", 32'(rd_valid), 0);
    chk("idx7_dirty", 32'(rd_dirty), 0);

    // Random traffic, checked every cycle by cycle()
    for (int k = 0; k < 300; k++) begin
      wr_en    = 1'($urandom_range(0, 1));
      wr_index = IW'($urandom_range(0, NL - 1));
      wr_way   = WW'($urandom_range(0, NW - 1));
      wr_op    = 2'($urandom_range(0, 3));
      rd_en    = 1'($urandom_range(0, 1));
      rd_index = ($urandom_range(0, 3) == 0) ? wr_index : IW'($urandom_range(0, NL - 1));
      cycle();
    end

    // Reset mid-traffic
    async_reset("midtraffic");
    read_all();

    // Clean flush: every entry filled (dirty cleared), one invalidated
    for (int e = 0; e < NE; e++) do_write(e / NW, e % NW, OP_FILL);
    do_write(2, 1, OP_INVALIDATE);
    run_flush(0, n);
    chk("clean_flush_latency", 32'(n), 32'(1 + NE));
    read_all();

    // Dirty flush: idx 3 way 1 dirty, ack held off for 4 cycles
    do_write(0, 0, OP_FILL);
    do_write(6, 1, OP_FILL);
    do_write(3, 1, OP_FILL);
    do_write(3, 1, OP_MARK_DIRTY);
    exp_n = 1 + NE;
    for (int e = 0; e < NE; e++)
      if (m_valid[e / NW][e % NW] && m_dirty[e / NW][e % NW]) exp_n += 4 + 1;
    run_flush(4, n);
    chk("dirty_flush_latency", 32'(n), 32'(exp_n));
    read_all();

    // Reset while waiting on writeback: walk aborts, no done pulse
    do_write(3, 1, OP_FILL);
    do_write(3, 1, OP_MARK_DIRTY);
    exp_wb = m_valid[3][1] && m_dirty[3][1];
    flush_req = 1'b1;
    cycle();
    flush_req = 1'b0;
    m_busy = 1'b1;
    for (int e = 0; e < 8; e++) cycle();
    chk("abort_wb_req_pre", 32'(wb_req), 32'(exp_wb));
    chk("abort_busy_pre", 32'(flush_busy), 1);
    async_reset("abort");
    for (int k = 0; k < 20; k++) begin
      cycle();
      chk("abort_no_done", 32'(flush_done), 0);
      chk("abort_no_busy", 32'(flush_busy), 0);
    end
    read_all();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
